// File: rtl/llvga_stream.sv
// llvga_stream: raster timing generator (hsync/vsync/de) driven by a runtime
// video mode, displaying pixels pulled from a valid/ready stream that carries
// start-of-frame (i_user) and end-of-line (i_last) markers. Any underflow or
// framing error blanks the pixel, pulses o_underflow and drops back to a
// resync state that waits for the next start-of-frame at raster (0,0).
module llvga_stream #(
    parameter int unsigned BPC           = 4,
    parameter int unsigned LGDIM         = 12,
    parameter bit          OPT_HOLD_MODE = 1'b1
) (
    input  logic               i_pixclk,
    input  logic               i_reset,
    input  logic [LGDIM-1:0]   i_hm_width,
    input  logic [LGDIM-1:0]   i_hm_porch,
    input  logic [LGDIM-1:0]   i_hm_synch,
    input  logic [LGDIM-1:0]   i_hm_raw,
    input  logic [LGDIM-1:0]   i_vm_height,
    input  logic [LGDIM-1:0]   i_vm_porch,
    input  logic [LGDIM-1:0]   i_vm_synch,
    input  logic [LGDIM-1:0]   i_vm_raw,
    input  logic               i_hpol,
    input  logic               i_vpol,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [3*BPC-1:0]   i_pixel,
    input  logic               i_user,
    input  logic               i_last,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_de,
    output logic [BPC-1:0]     o_red,
    output logic [BPC-1:0]     o_grn,
    output logic [BPC-1:0]     o_blu,
    output logic               o_newframe,
    output logic               o_underflow,
    output logic               o_locked
);

    localparam int unsigned      PW  = 3 * BPC;
    localparam logic [LGDIM-1:0] One = LGDIM'(1);

    typedef enum logic [0:0] {StResync, StRun} state_e;

    state_e state_q, state_d;

    // Effective mode: either the per-frame shadow or the live inputs
    logic [LGDIM-1:0] hm_width, hm_porch, hm_synch, hm_raw;
    logic [LGDIM-1:0] vm_height, vm_porch, vm_synch, vm_raw;
    logic             hpol, vpol;

    logic [LGDIM-1:0] hpos_q, vpos_q;

    logic h_end, v_end;
    logic active, origin, line_last;
    logic h_sync_on, v_sync_on;
    logic sof_take, pix_err, show, ready_c;

    logic [BPC-1:0] pix_red, pix_grn, pix_blu;

    logic           hsync_q, vsync_q, de_q, newframe_q, underflow_q;
    logic [BPC-1:0] red_q, grn_q, blu_q;

    // ------------------------------------------------------------------
    // Mode selection
    // ------------------------------------------------------------------
    generate
        if (OPT_HOLD_MODE) begin : g_hold
            logic [LGDIM-1:0] hm_width_q, hm_porch_q, hm_synch_q, hm_raw_q;
            logic [LGDIM-1:0] vm_height_q, vm_porch_q, vm_synch_q, vm_raw_q;
            logic             hpol_q, vpol_q;
            logic             frame_end;

            assign frame_end = h_end && v_end;

            // Shadow the mode at reset and on the final pixel of every frame
            always_ff @(posedge i_pixclk) begin
                if (i_reset || frame_end) begin
                    hm_width_q  <= i_hm_width;
                    hm_porch_q  <= i_hm_porch;
                    hm_synch_q  <= i_hm_synch;
                    hm_raw_q    <= i_hm_raw;
                    vm_height_q <= i_vm_height;
                    vm_porch_q  <= i_vm_porch;
                    vm_synch_q  <= i_vm_synch;
                    vm_raw_q    <= i_vm_raw;
                    hpol_q      <= i_hpol;
                    vpol_q      <= i_vpol;
                end
            end

            assign hm_width  = hm_width_q;
            assign hm_porch  = hm_porch_q;
            assign hm_synch  = hm_synch_q;
            assign hm_raw    = hm_raw_q;
            assign vm_height = vm_height_q;
            assign vm_porch  = vm_porch_q;
            assign vm_synch  = vm_synch_q;
            assign vm_raw    = vm_raw_q;
            assign hpol      = hpol_q;
            assign vpol      = vpol_q;
        end else begin : g_live
            assign hm_width  = i_hm_width;
            assign hm_porch  = i_hm_porch;
            assign hm_synch  = i_hm_synch;
            assign hm_raw    = i_hm_raw;
            assign vm_height = i_vm_height;
            assign vm_porch  = i_vm_porch;
            assign vm_synch  = i_vm_synch;
            assign vm_raw    = i_vm_raw;
            assign hpol      = i_hpol;
            assign vpol      = i_vpol;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Raster position decode
    // ------------------------------------------------------------------
    // >= rather than == so a live mode shrinking under the counter still wraps
    assign h_end     = (hpos_q >= hm_raw - One);
    assign v_end     = (vpos_q >= vm_raw - One);
    assign active    = (hpos_q < hm_width) && (vpos_q < vm_height);
    assign origin    = (hpos_q == '0) && (vpos_q == '0);
    assign line_last = (hpos_q == hm_width - One);
    assign h_sync_on = (hpos_q >= hm_porch) && (hpos_q < hm_synch);
    assign v_sync_on = (vpos_q >= vm_porch) && (vpos_q < vm_synch);

    assign sof_take  = origin && i_valid && i_user;

    assign pix_red   = i_pixel[PW-1 -: BPC];
    assign pix_grn   = i_pixel[2*BPC-1 -: BPC];
    assign pix_blu   = i_pixel[BPC-1:0];

    // Free-running position counters; errors never stall timing
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            hpos_q <= '0;
            vpos_q <= '0;
        end else if (h_end) begin
            hpos_q <= '0;
            vpos_q <= v_end ? '0 : vpos_q + One;
        end else begin
            hpos_q <= hpos_q + One;
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            state_q <= StResync;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: lock on an SOF at (0,0), fall back on any stream error
    always_comb begin
        state_d = state_q;
        case (state_q)
            StResync: if (sof_take) state_d = StRun;
            StRun:    if (pix_err)  state_d = StResync;
            default:  state_d = StResync;
        endcase
    end

    // Handshake, error detection and pixel display decision per state
    always_comb begin
        ready_c = 1'b0;
        pix_err = 1'b0;
        show    = 1'b0;
        case (state_q)
            StResync: begin
                // Drain non-SOF pixels; hold an SOF pixel until (0,0)
                ready_c = i_valid && (!i_user || origin);
                show    = sof_take;
            end
            StRun: begin
                ready_c = active;
                pix_err = active && (!i_valid || (i_user != origin) ||
                                     (i_last != line_last));
                show    = active && !pix_err;
            end
            default: ;
        endcase
    end

    assign o_ready = ready_c;

    // ------------------------------------------------------------------
    // Output registers, one cycle behind the raster position
    // ------------------------------------------------------------------
    // Registered timing and colour outputs; reset parks syncs at idle level
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            hsync_q     <= !i_hpol;
            vsync_q     <= !i_vpol;
            de_q        <= 1'b0;
            red_q       <= '0;
            grn_q       <= '0;
            blu_q       <= '0;
            newframe_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            hsync_q     <= hpol ^ !h_sync_on;
            vsync_q     <= vpol ^ !v_sync_on;
            de_q        <= active;
            red_q       <= show ? pix_red : '0;
            grn_q       <= show ? pix_grn : '0;
            blu_q       <= show ? pix_blu : '0;
            newframe_q  <= origin;
            underflow_q <= pix_err;
        end
    end

    assign o_hsync     = hsync_q;
    assign o_vsync     = vsync_q;
    assign o_de        = de_q;
    assign o_red       = red_q;
    assign o_grn       = grn_q;
    assign o_blu       = blu_q;
    assign o_newframe  = newframe_q;
    assign o_underflow = underflow_q;
    assign o_locked    = (state_q == StRun);

endmodule

// File: tb/tb_llvga_stream.sv
// Bench for llvga_stream: constant timing table, hand sequences for the
// multi-cycle corner cases, and a randomized run against a frame-level model.
module tb_llvga_stream;

    localparam int BPC = 4;
    localparam int LGDIM = 12;
    localparam int PW = 3 * BPC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [LGDIM-1:0] hm_w, hm_p, hm_s, hm_r, vm_h, vm_p, vm_s, vm_r;
    logic             hpol, vpol, valid, user, last;
    logic [PW-1:0]    pixel;

    logic           ready, hsync, vsync, de, nf, uf, locked;
    logic [BPC-1:0] red, grn, blu;
    logic           l_ready, l_hsync, l_vsync, l_de, l_nf, l_uf, l_locked;
    logic [BPC-1:0] l_red, l_grn, l_blu;

    llvga_stream #(.BPC(BPC), .LGDIM(LGDIM), .OPT_HOLD_MODE(1'b1)) u_dut (
        .i_pixclk(clk), .i_reset(rst),
        .i_hm_width(hm_w), .i_hm_porch(hm_p), .i_hm_synch(hm_s), .i_hm_raw(hm_r),
        .i_vm_height(vm_h), .i_vm_porch(vm_p), .i_vm_synch(vm_s), .i_vm_raw(vm_r),
        .i_hpol(hpol), .i_vpol(vpol), .i_valid(valid), .o_ready(ready),
        .i_pixel(pixel), .i_user(user), .i_last(last),
        .o_hsync(hsync), .o_vsync(vsync), .o_de(de),
        .o_red(red), .o_grn(grn), .o_blu(blu),
        .o_newframe(nf), .o_underflow(uf), .o_locked(locked)
    );

    llvga_stream #(.BPC(BPC), .LGDIM(LGDIM), .OPT_HOLD_MODE(1'b0)) u_live (
        .i_pixclk(clk), .i_reset(rst),
        .i_hm_width(hm_w), .i_hm_porch(hm_p), .i_hm_synch(hm_s), .i_hm_raw(hm_r),
        .i_vm_height(vm_h), .i_vm_porch(vm_p), .i_vm_synch(vm_s), .i_vm_raw(vm_r),
        .i_hpol(hpol), .i_vpol(vpol), .i_valid(valid), .o_ready(l_ready),
        .i_pixel(pixel), .i_user(user), .i_last(last),
        .o_hsync(l_hsync), .o_vsync(l_vsync), .o_de(l_de),
        .o_red(l_red), .o_grn(l_grn), .o_blu(l_blu),
        .o_newframe(l_nf), .o_underflow(l_uf), .o_locked(l_locked)
    );

    int errors = 0;
    int checks = 0;

    // Frame-level model of the hold-mode instance
    int   mh, mv;
    int   s_hw, s_hp, s_hs, s_hr, s_vh, s_vp, s_vs, s_vr;
    logic s_hpol, s_vpol;
    logic mlocked = 1'b0;
    logic model_ok = 1'b0;
    logic last_ready;

    // Pixel source: walks a frame of width hm_w x height vm_h
    int   src_h = 0, src_v = 0;
    logic src_on = 1'b0, pix_rand = 1'b0;
    logic force_drop = 1'b0, force_last = 1'b0, force_user = 1'b0;

    typedef struct {
        int         h;
        int         v;
        logic [3:0] exp_v; // {de, hsync, vsync, newframe}
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp_v, $time);
        end
    endtask

    task automatic latch_mode();
        s_hw = int'(hm_w); s_hp = int'(hm_p); s_hs = int'(hm_s); s_hr = int'(hm_r);
        s_vh = int'(vm_h); s_vp = int'(vm_p); s_vs = int'(vm_s); s_vr = int'(vm_r);
        s_hpol = hpol; s_vpol = vpol;
    endtask

    task automatic set_mode(input bit alt);
        if (alt) begin
            hm_w = 3; hm_p = 4; hm_s = 6; hm_r = 7; vm_h = 2; vm_p = 3; vm_s = 4; vm_r = 5;
        end else begin
            hm_w = 4; hm_p = 5; hm_s = 6; hm_r = 8; vm_h = 3; vm_p = 4; vm_s = 5; vm_r = 6;
        end
    endtask

    task automatic drive();
        logic nat_user, nat_last;
        nat_user = (src_h == 0) && (src_v == 0);
        nat_last = (src_h == int'(hm_w) - 1);
        valid = src_on && !force_drop;
        user  = nat_user ^ force_user;
        last  = nat_last ^ force_last;
        pixel = pix_rand ? 12'($urandom) : {6'(src_v), 6'(src_h)};
    endtask

    // One clock: predict, check o_ready before the edge, check outputs after
    task automatic cycle();
        logic        act, org, rdy, bad, show, nxt_lock, rst_s, v_s;
        logic [11:0] pix_s;
        logic [17:0] exp_o;
        #2;
        act = (mh < s_hw) && (mv < s_vh);
        org = (mh == 0) && (mv == 0);
        rdy = mlocked ? act : (valid && (!user || org));
        bad = mlocked && act && (!valid || (user != org) || (last != (mh == s_hw - 1)));
        show = mlocked ? (act && !bad) : (org && valid && user);
        nxt_lock = mlocked ? !bad : (org && valid && user);
        last_ready = ready;
        if (model_ok) check("ready", ready, rdy);
        rst_s = rst; v_s = valid; pix_s = pixel;
        if (rst_s)
            exp_o = {!hpol, !vpol, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
        else
            exp_o = {s_hpol ^ !(mh >= s_hp && mh < s_hs), s_vpol ^ !(mv >= s_vp && mv < s_vs),
                     act, show ? pix_s : 12'h000, org, bad, nxt_lock};
        @(posedge clk);
        #1;
        if (model_ok || rst_s)
            check("outputs", {hsync, vsync, de, red, grn, blu, nf, uf, locked}, exp_o);
        if (model_ok && v_s && rdy) begin
            src_h++;
            if (src_h >= int'(hm_w)) begin
                src_h = 0;
                src_v++;
                if (src_v >= int'(vm_h)) src_v = 0;
            end
        end
        if (rst_s) begin
            mh = 0; mv = 0; mlocked = 1'b0; model_ok = 1'b1;
            latch_mode();
        end else begin
            mlocked = nxt_lock;
            if (mh == s_hr - 1) begin
                mh = 0;
                if (mv == s_vr - 1) begin
                    mv = 0;
                    latch_mode();
                end else begin
                    mv++;
                end
            end else begin
                mh++;
            end
        end
    endtask

    task automatic step();
        drive();
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive();
        valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic run_until_pos(input int h, input int v, input logic need_lock);
        logic found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (mh == h && mv == v && (!need_lock || mlocked)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("wait_pos", found, 1'b1);
    endtask

    initial begin
        int cnt_de, cnt_nf, cnt_hs, cnt_vs, cnt_lk, cnt_uf, nf_first, nf_gap;
        int cnt_lde, cnt_lhs, cnt_lnf, held;
        logic relocked, nf_at_lock;

        tbl[0]  = '{0, 0, 4'b1001};
        tbl[1]  = '{3, 0, 4'b1000};
        tbl[2]  = '{4, 0, 4'b0000};
        tbl[3]  = '{5, 0, 4'b0100};
        tbl[4]  = '{6, 0, 4'b0000};
        tbl[5]  = '{3, 2, 4'b1000};
        tbl[6]  = '{7, 2, 4'b0000};
        tbl[7]  = '{0, 3, 4'b0000};
        tbl[8]  = '{0, 4, 4'b0010};
        tbl[9]  = '{5, 4, 4'b0110};
        tbl[10] = '{7, 4, 4'b0010};
        tbl[11] = '{2, 5, 4'b0000};

        rst = 1'b1; hpol = 1'b1; vpol = 1'b1;
        valid = 1'b0; user = 1'b0; last = 1'b0; pixel = '0;
        set_mode(1'b0);

        // Reset state
        do_reset();
        check("rst_state", {locked, de, uf, nf, red, grn, blu, ready}, 0);
        check("rst_syncs", {hsync, vsync}, 2'b00);

        // Timing table with an idle source
        for (int t = 0; t < 48; t++) begin
            step();
            for (int k = 0; k < 12; k++)
                if (tbl[k].v * 8 + tbl[k].h == t)
                    check($sformatf("tbl_%0d_%0d", tbl[k].h, tbl[k].v),
                          {de, hsync, vsync, nf}, tbl[k].exp_v);
        end

        // Steady locked stream for two frames
        src_on = 1'b1; src_h = 0; src_v = 0;
        do_reset();
        cnt_de = 0; cnt_nf = 0; cnt_hs = 0; cnt_vs = 0; cnt_lk = 0; cnt_uf = 0;
        nf_first = -1; nf_gap = 0;
        for (int t = 0; t < 96; t++) begin
            step();
            cnt_de += int'(de); cnt_hs += int'(hsync); cnt_vs += int'(vsync);
            cnt_lk += int'(locked); cnt_uf += int'(uf);
            if (nf) begin
                cnt_nf++;
                if (nf_first < 0) nf_first = t; else nf_gap = t - nf_first;
            end
            if (t == 19) check("colour_3_2", {red, grn, blu}, 12'h083);
        end
        check("de_count", cnt_de, 24);
        check("nf_count", cnt_nf, 2);
        check("nf_gap", nf_gap, 48);
        check("hsync_count", cnt_hs, 12);
        check("vsync_count", cnt_vs, 16);
        check("locked_count", cnt_lk, 96);
        check("uf_quiet", cnt_uf, 0);

        // Inverted polarity: syncs idle high
        hpol = 1'b0; vpol = 1'b0;
        do_reset();
        check("pol0_rst", {hsync, vsync}, 2'b11);
        cnt_hs = 0; cnt_vs = 0;
        for (int t = 0; t < 48; t++) begin
            step();
            cnt_hs += int'(hsync); cnt_vs += int'(vsync);
        end
        check("pol0_hs_high", cnt_hs, 42);
        check("pol0_vs_high", cnt_vs, 40);
        hpol = 1'b1; vpol = 1'b1;
        do_reset();

        // Underflow at (2,1)
        run_until_pos(2, 1, 1'b1);
        force_drop = 1'b1;
        step();
        force_drop = 1'b0;
        check("uf_pulse", {uf, locked, red, grn, blu}, {1'b1, 1'b0, 12'h000});
        cnt_uf = 0; relocked = 1'b0; nf_at_lock = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            cnt_uf += int'(uf);
            if (locked) begin
                relocked = 1'b1;
                nf_at_lock = nf;
                break;
            end
        end
        check("uf_single", cnt_uf, 0);
        check("relock", relocked, 1'b1);
        check("relock_at_origin", nf_at_lock, 1'b1);

        // Framing error: i_last at hpos 2
        run_until_pos(2, 0, 1'b1);
        force_last = 1'b1;
        step();
        force_last = 1'b0;
        check("last_err", {uf, locked}, 2'b10);
        run_until_pos(0, 0, 1'b0);
        step();
        check("last_relock", locked, 1'b1);

        // SOF presented mid-frame in resync is held until (0,0)
        src_on = 1'b0;
        do_reset();
        run_until_pos(1, 1, 1'b0);
        src_h = 0; src_v = 0; src_on = 1'b1;
        held = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (last_ready) break;
            held++;
        end
        check("sof_held_cycles", held, 39);
        check("sof_locked", locked, 1'b1);

        // Width change mid-frame: shadowed vs live
        src_on = 1'b0;
        do_reset();
        run_until_pos(6, 1, 1'b0);
        hm_w = 3;
        step();
        step();
        cnt_de = 0; cnt_lde = 0; cnt_lhs = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            cnt_de += int'(de); cnt_lde += int'(l_de); cnt_lhs += int'(l_hsync);
        end
        check("hold_width_line", cnt_de, 4);
        check("live_width_line", cnt_lde, 3);
        check("live_hsync_line", cnt_lhs, 1);
        check("live_idle", {l_locked, l_uf, l_red, l_grn, l_blu, l_ready, l_vsync}, 0);
        run_until_pos(0, 0, 1'b0);
        cnt_de = 0; cnt_lnf = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            cnt_de += int'(de); cnt_lnf += int'(l_nf);
        end
        check("hold_width_next", cnt_de, 3);
        check("live_nf", cnt_lnf, 1);
        hm_w = 4;

        // One-cycle reset at (3,2) while locked
        src_on = 1'b1; src_h = 0; src_v = 0;
        do_reset();
        run_until_pos(3, 2, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_outputs", {locked, de, uf, nf, red, grn, blu, hsync, vsync}, 0);
        step();
        check("midrst_restart", {nf, de}, 2'b11);

        // Randomized run
        pix_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            force_drop = ($urandom_range(15) == 0);
            force_last = ($urandom_range(63) == 0);
            force_user = ($urandom_range(63) == 0);
            rst = ($urandom_range(499) == 0);
            if ($urandom_range(399) == 0) set_mode(1'($urandom_range(1)));
            step();
        end
        force_drop = 1'b0; force_last = 1'b0; force_user = 1'b0; rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
